// File: rtl/stopwatch_bcd.sv
// BCD stopwatch (ss.cc) with start/stop, clear and optional lap hold.
// Optional lap feature: define STOPWATCH_LAP_EN to build the LAP state and lap register.
module stopwatch_bcd #(
  parameter int ROLLOVER_STOP = 0
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start_stop_n,
  input  logic        lap_n,
  input  logic        clear_n,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        wrap_pulse
);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

  localparam logic [15:0] DIGIT_MAX = 16'h5999;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d, count_inc;
  logic [4:0]  carry;
  logic        tick_q, start_prev_q, clear_prev_q;
  logic        running_q, running_d, wrap_q;
  logic        tick_ev, start_ev, clear_ev, counting;

  assign tick_ev  = tick_in & ~tick_q;
  assign start_ev = ~start_stop_n & start_prev_q;
  assign clear_ev = ~clear_n & clear_prev_q;

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_reg_q;
  logic        lap_prev_q, lap_active_q, lap_ev;
  assign lap_ev     = ~lap_n & lap_prev_q;
  assign counting   = (state_q == RUN) || (state_q == LAP);
  assign running_d  = (state_d == RUN) || (state_d == LAP);
  assign disp_bcd   = (state_q == LAP) ? lap_reg_q : count_q;
  assign lap_active = lap_active_q;
`else
  logic unused_lap_n;
  assign unused_lap_n = lap_n;
  assign counting     = (state_q == RUN);
  assign running_d    = (state_d == RUN);
  assign disp_bcd     = count_q;
  assign lap_active   = 1'b0;
`endif

  // Ripple carry through the four digits; carry[4] means the count passes 59.99.
  assign carry[0] = tick_ev & counting;
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] dig;
    assign dig                    = count_q[4*gi +: 4];
    assign carry[gi+1]            = carry[gi] & (dig == DIGIT_MAX[4*gi +: 4]);
    assign count_inc[4*gi +: 4]   = !carry[gi] ? dig : (carry[gi+1] ? 4'd0 : dig + 4'd1);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_inc;
    if (carry[4] && ROLLOVER_STOP != 0) count_d = count_q;
    case (state_q)
      IDLE:  if (start_ev) state_d = RUN;
`ifdef STOPWATCH_LAP_EN
      RUN: begin
        if (start_ev)    state_d = PAUSE;
        else if (lap_ev) state_d = LAP;
      end
      LAP: begin
        if (start_ev)    state_d = PAUSE;
        else if (lap_ev) state_d = RUN;
      end
`else
      RUN:   if (start_ev) state_d = PAUSE;
`endif
      PAUSE: begin
        if (clear_ev) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    // Saturating mode stops the watch at 59.99, overriding any button event.
    if (carry[4] && ROLLOVER_STOP != 0) state_d = PAUSE;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      tick_q       <= 1'b1;
      start_prev_q <= 1'b1;
      clear_prev_q <= 1'b1;
      running_q    <= 1'b0;
      wrap_q       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_reg_q    <= '0;
      lap_prev_q   <= 1'b1;
      lap_active_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tick_q       <= tick_in;
      start_prev_q <= start_stop_n;
      clear_prev_q <= clear_n;
      running_q    <= running_d;
      wrap_q       <= carry[4];
`ifdef STOPWATCH_LAP_EN
      lap_prev_q   <= lap_n;
      lap_active_q <= (state_d == LAP);
      if (state_q == RUN && state_d == LAP) lap_reg_q <= count_q;
`endif
    end
  end

  assign running    = running_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter ROLLOVER_STOP, default 0, meaning 0 = wrap 59.99->00.00, 1 = saturate at 59.99 and pause.
REQ-002 SHALL have port clock_in  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick_in  input  1  divided-clock square wave (nominal 100 Hz toggle rate), synchronous to clock_in.
REQ-005 SHALL have port start_stop_n  input  1  active-low button level, synchronous to clock_in.
REQ-006 SHALL have port lap_n  input  1  active-low button level, synchronous to clock_in.
REQ-007 SHALL have port clear_n  input  1  active-low button level, synchronous to clock_in.
REQ-008 SHALL have port disp_bcd  output  16  BCD display {sec_tens, sec_ones, tenths, hundredths}.
REQ-009 SHALL have port running  output  1  high in RUN or LAP.
REQ-010 SHALL have port lap_active  output  1  high in LAP.
REQ-011 SHALL have port wrap_pulse  output  1  one-cycle pulse when count passes 59.99.

Function
REQ-012 SHALL detect a tick event when tick_in=1 and registered tick_q=0; no synchronizer or debounce inside the block.
REQ-013 SHALL detect a button event on each input's 1->0 transition against its registered previous value; a held button yields one event.
REQ-014 SHALL implement states IDLE, RUN, LAP, PAUSE.
REQ-015 SHALL transition IDLE: start -> RUN; lap/clear ignored.
REQ-016 SHALL transition RUN: start -> PAUSE; lap -> LAP, capturing current count into the lap register on the same edge; clear ignored.
REQ-017 SHALL transition LAP: lap -> RUN; start -> PAUSE; clear ignored; counting continues.
REQ-018 SHALL transition PAUSE: start -> RUN; clear -> IDLE with count zeroed; lap ignored.
REQ-019 SHALL apply priority clear > start_stop > lap when events coincide; lower-priority events that cycle are discarded.
REQ-020 SHALL increment count on a tick event when the current (registered) state is RUN or LAP, even if a stop event occurs the same cycle.
REQ-021 SHALL count digits in BCD: hundredths 0-9, tenths 0-9, sec_ones 0-9, sec_tens 0-5, each carrying into the next.
REQ-022 SHALL, with ROLLOVER_STOP=0, wrap 59.99 -> 00.00 on a tick and pulse wrap_pulse for one cycle.
REQ-023 SHALL, with ROLLOVER_STOP=1, hold 59.99 on a tick, pulse wrap_pulse, and force state to PAUSE (overriding any coincident lap event).
REQ-024 SHALL drive disp_bcd from the lap register in LAP, else from the live count, with zero added latency.
REQ-025 SHALL register running, lap_active and wrap_pulse.

Reset
REQ-026 SHALL on reset=1 at a clock edge set state IDLE, count 00.00, lap register 00.00, wrap_pulse 0, running 0, lap_active 0.
REQ-027 SHALL reset tick_q and all button previous-value registers to 1, so no event is generated on the first cycle after reset.
REQ-028 SHALL give reset priority over all events, including mid-count and in LAP.

Configuration
REQ-029 SHALL honour macro STOPWATCH_LAP_EN: defined -> LAP state, lap register and lap_active as specified.
REQ-030 SHALL, without STOPWATCH_LAP_EN, omit the LAP state and lap register, ignore lap_n, tie lap_active to 0, and drive disp_bcd always from live count.

Verification
REQ-031 SHALL cover: reset, start event, 150 ticks -> disp_bcd=16'h0150, running=1.
REQ-032 SHALL cover: RUN at 12.34, lap event, 10 ticks -> disp_bcd=16'h1234, lap_active=1; lap again -> disp_bcd=16'h1244.
REQ-033 SHALL cover: ROLLOVER_STOP=0, count 59.99, one tick -> disp_bcd=16'h0000, wrap_pulse high exactly one cycle, running=1.
REQ-034 SHALL cover: ROLLOVER_STOP=1, count 59.99, one tick -> disp_bcd=16'h5999, wrap_pulse one cycle, running=0 (PAUSE).
REQ-035 SHALL cover: PAUSE at 03.07, clear and start falling in same cycle -> IDLE, disp_bcd=16'h0000, running=0.
REQ-036 SHALL cover: RUN, tick event and start event same cycle at 00.09 -> disp_bcd=16'h0010, state PAUSE; further ticks leave 16'h0010.
